// File: rtl/mem_arb_pkg.sv
// Shared definitions for the memory port arbiter.
//   requester_t      : identifies which requester owns an issue slot / response
//   *_DEFAULT        : default bus widths, shared with memory_bus
//   other_requester(): the round-robin partner of a given requester
package mem_arb_pkg;

    localparam int ADDR_W_DEFAULT          = 16;
    localparam int DATA_W_DEFAULT          = 32;
    localparam int MAX_OUTSTANDING_DEFAULT = 4;

    typedef enum logic {
        REQ_CPU = 1'b0,
        REQ_DMA = 1'b1
    } requester_t;

    function automatic requester_t other_requester(input requester_t r);
        return (r == REQ_CPU) ? REQ_DMA : REQ_CPU;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_owner_fifo.sv
// owner_fifo: small synchronous FIFO recording the owner of each outstanding
// read, in issue order. Memory responses are in order, so the head entry is
// always the owner of the next response.
//   clk, rst_n  : clock, asynchronous active-low reset (clears pointers/count)
//   push, din   : append an owner (ignored when full)
//   pop, dout   : drop the head; dout shows the head combinationally
//   full, empty : occupancy flags
//   count       : number of stored entries, 0..DEPTH
module owner_fifo
    import mem_arb_pkg::*;
#(
    parameter int DEPTH = MAX_OUTSTANDING_DEFAULT,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  requester_t       din,
    output requester_t       dout,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    requester_t       mem_reg [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_reg == CNT_W'(DEPTH));
    assign empty   = (count_reg == '0);
    assign count   = count_reg;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // The owner of the current response must be known in the same cycle the
    // response arrives, so the head is read without a register stage.
    assign dout = mem_reg[rd_ptr_reg];

    // DEPTH is a power of two, so pointer wrap is plain binary overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + CNT_W'(1);
                2'b01:   count_reg <= count_reg - CNT_W'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    // Storage needs no reset: an entry is only read after it was written.
    always_ff @(posedge clk) begin
        if (do_push) mem_reg[wr_ptr_reg] <= din;
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares the single memory_system port between the CPU and
// the DMA/blitter engine with round-robin issue arbitration, and routes each
// in-order read response back to the requester that issued the read.
//   clk_in, rst_in            : clock, asynchronous active-low reset
//   cpu_* / dma_*             : requester ports (req held until gnt; gnt is a
//                               same-cycle accept pulse; rvalid/rdata response)
//   m_req/we/addr/wdata_out   : request to memory_system
//   m_ready_in                : memory_system accepts the request this cycle
//   m_rvalid_in, m_rdata_in   : in-order read response
//   err_out                   : sticky, set by a response with no read pending
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W          = ADDR_W_DEFAULT,
    parameter int DATA_W          = DATA_W_DEFAULT,
    parameter int MAX_OUTSTANDING = MAX_OUTSTANDING_DEFAULT
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              cpu_req_in,
    input  logic              cpu_we_in,
    input  logic [ADDR_W-1:0] cpu_addr_in,
    input  logic [DATA_W-1:0] cpu_wdata_in,
    output logic              cpu_gnt_out,
    output logic              cpu_rvalid_out,
    output logic [DATA_W-1:0] cpu_rdata_out,
    input  logic              dma_req_in,
    input  logic              dma_we_in,
    input  logic [ADDR_W-1:0] dma_addr_in,
    input  logic [DATA_W-1:0] dma_wdata_in,
    output logic              dma_gnt_out,
    output logic              dma_rvalid_out,
    output logic [DATA_W-1:0] dma_rdata_out,
    output logic              m_req_out,
    output logic              m_we_out,
    output logic [ADDR_W-1:0] m_addr_out,
    output logic [DATA_W-1:0] m_wdata_out,
    input  logic              m_ready_in,
    input  logic              m_rvalid_in,
    input  logic [DATA_W-1:0] m_rdata_in,
    output logic              err_out
);

    localparam int CNT_W = $clog2(MAX_OUTSTANDING) + 1;

    requester_t       last_winner_reg;
    logic             err_reg;
    requester_t       winner;
    logic             has_winner;
    logic             blocked;
    logic             accept;
    logic             resp_valid;
    logic             fifo_push;
    logic             fifo_pop;
    requester_t       fifo_dout;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CNT_W-1:0] fifo_count;

    // Winner select: a lone requester wins; on a tie the one that did not win
    // last time wins. With nobody requesting, winner stays CPU so the memory
    // side shows the CPU fields.
    always_comb begin
        has_winner = cpu_req_in | dma_req_in;
        winner     = REQ_CPU;
        if (cpu_req_in && dma_req_in) begin
            winner = other_requester(last_winner_reg);
        end else if (dma_req_in) begin
            winner = REQ_DMA;
        end
    end

    assign m_we_out    = (winner == REQ_DMA) ? dma_we_in    : cpu_we_in;
    assign m_addr_out  = (winner == REQ_DMA) ? dma_addr_in  : cpu_addr_in;
    assign m_wdata_out = (winner == REQ_DMA) ? dma_wdata_in : cpu_wdata_in;

    // A read with no owner slot left stalls the port; the slot is not handed
    // to the other requester, which keeps the round-robin order intact.
    // Writes need no slot and always pass.
    assign blocked = fifo_full & ~m_we_out;

    // Outputs are gated with reset so nothing is issued or granted while the
    // arbiter is held in reset.
    assign m_req_out   = rst_in & has_winner & ~blocked;
    assign accept      = m_req_out & m_ready_in;
    assign cpu_gnt_out = accept & (winner == REQ_CPU);
    assign dma_gnt_out = accept & (winner == REQ_DMA);
    assign fifo_push   = accept & ~m_we_out;

    // Response steering: only rvalid follows the recorded owner.
    assign resp_valid     = rst_in & m_rvalid_in;
    assign fifo_pop       = resp_valid & ~fifo_empty;
    assign cpu_rvalid_out = fifo_pop & (fifo_dout == REQ_CPU);
    assign dma_rvalid_out = fifo_pop & (fifo_dout == REQ_DMA);
    assign cpu_rdata_out  = m_rdata_in;
    assign dma_rdata_out  = m_rdata_in;
    assign err_out        = err_reg;

    // Reset starts with DMA as last winner so the CPU takes the first tie.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            last_winner_reg <= REQ_DMA;
        end else if (accept) begin
            last_winner_reg <= winner;
        end
    end

    // A response with no read on record (e.g. a read issued before reset)
    // is discarded and flagged until the next reset.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            err_reg <= 1'b0;
        end else if (m_rvalid_in && (fifo_count == '0)) begin
            err_reg <= 1'b1;
        end
    end

    owner_fifo #(
        .DEPTH (MAX_OUTSTANDING)
    ) u_owner_fifo (
        .clk   (clk_in),
        .rst_n (rst_in),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (winner),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

    localparam int AW = 16;
    localparam int DW = 32;
    localparam int MO = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cpu_req, cpu_we, dma_req, dma_we;
    logic [AW-1:0] cpu_addr, dma_addr;
    logic [DW-1:0] cpu_wdata, dma_wdata;
    logic          cpu_gnt, cpu_rvalid, dma_gnt, dma_rvalid;
    logic [DW-1:0] cpu_rdata, dma_rdata;
    logic          m_req, m_we, m_ready, m_rvalid, err;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata, m_rdata;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .ADDR_W(AW), .DATA_W(DW), .MAX_OUTSTANDING(MO)
    ) dut (
        .clk_in         (clk),
        .rst_in         (rst_n),
        .cpu_req_in     (cpu_req),
        .cpu_we_in      (cpu_we),
        .cpu_addr_in    (cpu_addr),
        .cpu_wdata_in   (cpu_wdata),
        .cpu_gnt_out    (cpu_gnt),
        .cpu_rvalid_out (cpu_rvalid),
        .cpu_rdata_out  (cpu_rdata),
        .dma_req_in     (dma_req),
        .dma_we_in      (dma_we),
        .dma_addr_in    (dma_addr),
        .dma_wdata_in   (dma_wdata),
        .dma_gnt_out    (dma_gnt),
        .dma_rvalid_out (dma_rvalid),
        .dma_rdata_out  (dma_rdata),
        .m_req_out      (m_req),
        .m_we_out       (m_we),
        .m_addr_out     (m_addr),
        .m_wdata_out    (m_wdata),
        .m_ready_in     (m_ready),
        .m_rvalid_in    (m_rvalid),
        .m_rdata_in     (m_rdata),
        .err_out        (err)
    );

    int vectors     = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Owners of outstanding reads as a queue (0=CPU, 1=DMA), last winner, error flag.
    int   mq[$];
    int   m_last = 1;
    logic m_err  = 1'b0;

    int            e_w;
    logic          e_has, e_we, e_mreq, e_accept, e_pop;
    int            e_owner;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wdata;

    task automatic model_eval();
        e_has = cpu_req | dma_req;
        if (cpu_req && dma_req) e_w = 1 - m_last;
        else if (dma_req)       e_w = 1;
        else                    e_w = 0;
        e_we     = (e_w == 1) ? dma_we    : cpu_we;
        e_addr   = (e_w == 1) ? dma_addr  : cpu_addr;
        e_wdata  = (e_w == 1) ? dma_wdata : cpu_wdata;
        e_mreq   = e_has && !((mq.size() == MO) && !e_we);
        e_accept = e_mreq && m_ready;
        e_pop    = m_rvalid && (mq.size() > 0);
        e_owner  = e_pop ? mq[0] : -1;
    endtask

    always @(posedge clk) begin
        if (!rst_n) begin
            mq.delete();
            m_last = 1;
            m_err  = 1'b0;
        end else begin
            model_eval();
            if (m_rvalid && mq.size() == 0) m_err = 1'b1;
            if (e_pop) void'(mq.pop_front());
            if (e_accept) begin
                m_last = e_w;
                if (!e_we) mq.push_back(e_w);
            end
        end
    end

    // Single compare process: every cycle, away from the active edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_m_req", m_req, 0);
            chk("rst_gnt", {cpu_gnt, dma_gnt}, 0);
            chk("rst_rvalid", {cpu_rvalid, dma_rvalid}, 0);
            chk("rst_err", err, 0);
        end else begin
            model_eval();
            chk("m_req", m_req, e_mreq);
            chk("m_we", m_we, e_we);
            chk("m_addr", m_addr, e_addr);
            chk("m_wdata", m_wdata, e_wdata);
            chk("cpu_gnt", cpu_gnt, e_accept && e_w == 0);
            chk("dma_gnt", dma_gnt, e_accept && e_w == 1);
            chk("cpu_rvalid", cpu_rvalid, e_owner == 0);
            chk("dma_rvalid", dma_rvalid, e_owner == 1);
            chk("rdata_mirror", {cpu_rdata, dma_rdata}, {m_rdata, m_rdata});
            chk("err", err, m_err);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cyc();
        @(negedge clk);
        #1;
    endtask

    task automatic idle();
        cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
        dma_req = 0; dma_we = 0; dma_addr = '0; dma_wdata = '0;
        m_ready = 1; m_rvalid = 0; m_rdata = '0;
    endtask

    task automatic do_reset();
        idle();
        rst_n = 0;
        tick();
        tick();
        rst_n = 1;
    endtask

    logic cpu_gnt_s, dma_gnt_s;

    initial begin
        idle();
        rst_n = 0;
        tick();
        tick();
        cyc();
        chk("lit_reset_err", err, 0);
        chk("lit_reset_m_req", m_req, 0);
        tick();
        rst_n = 1;

        // Single CPU read, response two cycles after accept.
        cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0010;
        cyc();
        chk("lit_t1_gnt", cpu_gnt, 1);
        chk("lit_t1_addr", m_addr, 16'h0010);
        tick();
        cpu_req = 0;
        cyc();
        chk("lit_t1_gnt_pulse", cpu_gnt, 0);
        tick();
        m_rvalid = 1; m_rdata = 32'hDEADBEEF;
        cyc();
        chk("lit_t1_cpu_rvalid", cpu_rvalid, 1);
        chk("lit_t1_cpu_rdata", cpu_rdata, 32'hDEADBEEF);
        chk("lit_t1_dma_rvalid", dma_rvalid, 0);
        tick();

        // Both requesting reads continuously: alternate CPU first; FIFO fills after 4.
        do_reset();
        cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0100;
        dma_req = 1; dma_we = 0; dma_addr = 16'h0200;
        for (int i = 0; i < 6; i++) begin
            cyc();
            chk($sformatf("lit_rr_cpu_gnt%0d", i), cpu_gnt, (i < 4) && (i % 2 == 0));
            chk($sformatf("lit_rr_dma_gnt%0d", i), dma_gnt, (i < 4) && (i % 2 == 1));
            tick();
        end
        cpu_req = 0; dma_req = 0;
        for (int i = 0; i < 4; i++) begin
            m_rvalid = 1; m_rdata = 32'hA0 + 32'(i);
            cyc();
            chk($sformatf("lit_rr_cpu_rv%0d", i), cpu_rvalid, (i % 2 == 0));
            chk($sformatf("lit_rr_dma_rv%0d", i), dma_rvalid, (i % 2 == 1));
            tick();
        end
        m_rvalid = 0;

        // Full FIFO blocks reads, not writes; frees one cycle after a pop.
        do_reset();
        dma_req = 1; dma_we = 0; dma_addr = 16'h8000;
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk($sformatf("lit_full_fill%0d", i), dma_gnt, 1);
            tick();
        end
        cyc();
        chk("lit_full_m_req", m_req, 0);
        chk("lit_full_no_gnt", dma_gnt, 0);
        tick();
        dma_req = 0; cpu_req = 1; cpu_we = 1; cpu_addr = 16'h0042; cpu_wdata = 32'h1234_5678;
        cyc();
        chk("lit_full_write_gnt", cpu_gnt, 1);
        chk("lit_full_write_wdata", m_wdata, 32'h1234_5678);
        tick();
        cpu_req = 0; dma_req = 1; m_rvalid = 1;
        cyc();
        chk("lit_full_pop_still_blocked", dma_gnt, 0);
        chk("lit_full_pop_rvalid", dma_rvalid, 1);
        tick();
        m_rvalid = 0;
        cyc();
        chk("lit_full_after_pop_gnt", dma_gnt, 1);
        tick();
        dma_req = 0;
        for (int i = 0; i < 4; i++) begin
            m_rvalid = 1;
            cyc();
            chk($sformatf("lit_full_drain%0d", i), dma_rvalid, 1);
            tick();
        end
        m_rvalid = 0;

        // Spurious response sets sticky error.
        do_reset();
        m_rvalid = 1;
        cyc();
        chk("lit_err_no_rvalid", {cpu_rvalid, dma_rvalid}, 0);
        chk("lit_err_not_yet", err, 0);
        tick();
        m_rvalid = 0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk($sformatf("lit_err_sticky%0d", i), err, 1);
            tick();
        end
        do_reset();
        cyc();
        chk("lit_err_cleared", err, 0);
        tick();

        // Backpressure: request held stable, granted when ready rises.
        cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0ABC; m_ready = 0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk($sformatf("lit_bp_req%0d", i), m_req, 1);
            chk($sformatf("lit_bp_addr%0d", i), m_addr, 16'h0ABC);
            chk($sformatf("lit_bp_nognt%0d", i), cpu_gnt, 0);
            tick();
        end
        m_ready = 1;
        cyc();
        chk("lit_bp_gnt", cpu_gnt, 1);
        tick();

        // Second read outstanding, then reset mid-cycle; late response flags error.
        cpu_req = 0; dma_req = 1; dma_we = 0; dma_addr = 16'h0300;
        cyc();
        chk("lit_mr_dma_gnt", dma_gnt, 1);
        tick();
        dma_req = 0; cpu_req = 1; cpu_addr = 16'h0400; m_ready = 0;
        #2;
        rst_n = 0;
        #1;
        chk("lit_mr_req_low", m_req, 0);
        chk("lit_mr_gnt_low", cpu_gnt, 0);
        tick();
        tick();
        idle();
        rst_n = 1;
        m_rvalid = 1; m_rdata = 32'h5555_AAAA;
        cyc();
        chk("lit_mr_late_no_rvalid", {cpu_rvalid, dma_rvalid}, 0);
        tick();
        m_rvalid = 0;
        cyc();
        chk("lit_mr_late_err", err, 1);
        tick();

        // Randomized traffic checked by the model.
        do_reset();
        cpu_gnt_s = 0; dma_gnt_s = 0;
        for (int i = 0; i < 3000; i++) begin
            if (!cpu_req || cpu_gnt_s) begin
                cpu_req   = 1'($urandom_range(0, 1));
                cpu_we    = 1'($urandom_range(0, 1));
                cpu_addr  = AW'($urandom);
                cpu_wdata = $urandom;
            end
            if (!dma_req || dma_gnt_s) begin
                dma_req   = 1'($urandom_range(0, 1));
                dma_we    = 1'($urandom_range(0, 3) == 0);
                dma_addr  = AW'($urandom);
                dma_wdata = $urandom;
            end
            m_ready  = ($urandom_range(0, 9) < 7);
            m_rvalid = (mq.size() > 0) && ($urandom_range(0, 9) < 4);
            m_rdata  = $urandom;
            cyc();
            cpu_gnt_s = cpu_gnt;
            dma_gnt_s = dma_gnt;
            tick();
        end

        idle();
        tick();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single memory_system consumer port between two requesters: the CPU (data accesses) and a DMA/blitter engine that copies sprite data into the frame buffer region.
- Round-robin arbitration of issue slots.
- Tracks the owner of every outstanding read so each read response is routed back to the requester that issued it.
- Sits between the cpu/dma modules and memory_system; the memory_system side is unchanged.

Parameters:
- ADDR_W, 16, address width of every port.
- DATA_W, 32, data width of every port.
- MAX_OUTSTANDING, 4, depth of the read-owner FIFO (power of two, ≥2).

Ports:
- clk_in  input  1  system clock.
- rst_in  input  1  asynchronous, active-low reset.
- cpu_req_in  input  1  CPU access request; held until granted.
- cpu_we_in  input  1  1=write, 0=read.
- cpu_addr_in  input  ADDR_W  CPU address.
- cpu_wdata_in  input  DATA_W  CPU write data.
- cpu_gnt_out  output  1  request accepted this cycle.
- cpu_rvalid_out  output  1  read data valid for CPU.
- cpu_rdata_out  output  DATA_W  read data.
- dma_req_in, dma_we_in, dma_addr_in, dma_wdata_in, dma_gnt_out, dma_rvalid_out, dma_rdata_out: same as cpu_*, for the DMA.
- m_req_out  output  1  request to memory_system.
- m_we_out  output  1  write enable to memory_system.
- m_addr_out  output  ADDR_W  address to memory_system.
- m_wdata_out  output  DATA_W  write data to memory_system.
- m_ready_in  input  1  memory_system accepts m_req_out this cycle.
- m_rvalid_in  input  1  read response valid (in-order, ≥1 cycle after accept).
- m_rdata_in  input  DATA_W  read response data.
- err_out  output  1  sticky: response arrived with no outstanding read.

Behaviour:
- Reset (rst_in=0, async):
  - Clears the owner FIFO (count=0, pointers=0), sets last_winner=DMA (so CPU wins first tie) and clears err_out.
  - All gnt/rvalid/m_req outputs are 0 while reset is asserted.
  - Responses for reads issued before reset are dropped after reset; see the err_out rule below.
- Issue path (combinational select, registered state):
  - blocked = owner FIFO full (count==MAX_OUTSTANDING) AND the selected request is a read.
  - winner: only one requester valid → that one. Both valid → the requester ≠ last_winner.
  - m_req_out = winner exists AND !blocked. m_we/addr/wdata_out = the winner's fields. When there is no winner, m_* hold the CPU fields and m_req_out=0.
  - Accept = m_req_out & m_ready_in. The winner's gnt_out=1 in the accept cycle only. 0-cycle grant latency. The requester may drop or change its request the next cycle.
  - On accept: last_winner ← winner. If the access is a read, push the winner ID into the owner FIFO.
  - A blocked read does not pass the slot to the other requester in that cycle. Round-robin state is unchanged.
  - Writes are never blocked by a full FIFO.
- Response path:
  - m_rvalid_in=1 with count>0: pop the FIFO head and assert {owner}_rvalid_out=1 in the same cycle, with {owner}_rdata_out=m_rdata_in.
  - Both rdata outputs mirror m_rdata_in at all times; only rvalid is steered.
  - m_rvalid_in=1 with count==0: err_out←1 (sticky until reset). The response is discarded and no rvalid is asserted.
- Simultaneous push and pop: count stays unchanged and both pointers advance.
- Full FIFO plus concurrent pop: the read is still blocked that cycle (full is evaluated from registered count). It issues the next cycle.
- Pointers wrap modulo MAX_OUTSTANDING. count is $clog2(MAX_OUTSTANDING)+1 bits wide.
- Fairness: with both requesting continuously and memory always ready, grants alternate CPU, DMA, CPU, … No starvation beyond 1 slot.

Decomposition:
- Shared package mem_arb_pkg:
  - typedef enum logic {REQ_CPU=0, REQ_DMA=1} requester_t.
  - Default ADDR_W/DATA_W constants, shared with memory_bus.
- Sub-module owner_fifo: a synchronous FIFO of requester_t, depth MAX_OUTSTANDING.
  - Ports: push, pop, din, dout, full, empty, count.
  - Async active-low reset.
- The arbiter holds the round-robin flop, select mux, gnt/rvalid steering and err flag.

Test Plan:
- CPU read 0x0010 alone, m_ready_in=1, response 2 cycles later with m_rdata_in=0xDEADBEEF → cpu_gnt_out pulses 1 cycle; cpu_rvalid_out=1 with 0xDEADBEEF; dma_rvalid_out stays 0.
- CPU and DMA both request reads continuously for 6 cycles, memory always ready → grant order CPU, DMA, CPU, DMA; responses returned in order route to CPU, DMA, CPU, DMA.
- DMA issues 4 reads with no responses (MAX_OUTSTANDING=4), then a 5th read → m_req_out=0 and no grant. A CPU write the same cycle with DMA idle is granted. After one m_rvalid_in, the DMA read is granted the following cycle.
- m_rvalid_in=1 with no reads outstanding → err_out=1 and stays 1; no rvalid asserted. Only rst_in=0 clears err_out.
- Read pending with m_ready_in=0 for 3 cycles → m_req_out stays 1, m_addr_out stable, no gnt. Grant occurs when m_ready_in rises.
- Two reads outstanding, assert rst_in=0 mid-cycle → outputs go to 0 immediately. After release, the late m_rvalid_in sets err_out=1 and produces no rvalid to either requester.
